// File: rtl/pipeline_hazard_scoreboard.sv
// rtl/pipeline_hazard_scoreboard.sv - per-register RAW/WAW hazard scoreboard with redirect restore
//
// Purpose: tracks, per architectural register, the cycles left until its pending
// result is forwardable to the ID operand read. Issue stalls on RAW hazards, and
// a redirect squashes the youngest KILL_DEPTH issues and restores their counters.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_issue_valid              instruction in ID requests issue
//   i_issue_rs/_rt             source register addresses
//   i_issue_rs_rd/_rt_rd       source actually read
//   i_issue_rd, i_issue_wen    destination register and write enable
//   i_issue_lat                cycles after issue until the result is forwardable
//   i_redirect                 taken branch/jump in EX, squash youngest issues
//   o_stall                    hold IF/ID and PC, bubble into ID/EX
//   o_issue_fire               issue accepted this cycle
//   o_busy_mask                bit r set while register r is pending
//   o_stall_cycles             saturating count of stalled cycles
module pipeline_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 3,
  parameter int KILL_DEPTH = 2,
  parameter int PERF_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_issue_valid,
  input  logic [REG_AW-1:0]      i_issue_rs,
  input  logic [REG_AW-1:0]      i_issue_rt,
  input  logic                   i_issue_rs_rd,
  input  logic                   i_issue_rt_rd,
  input  logic [REG_AW-1:0]      i_issue_rd,
  input  logic                   i_issue_wen,
  input  logic [CNT_W-1:0]       i_issue_lat,
  input  logic                   i_redirect,
  output logic                   o_stall,
  output logic                   o_issue_fire,
  output logic [(1<<REG_AW)-1:0] o_busy_mask,
  output logic [PERF_W-1:0]      o_stall_cycles
);

  localparam int NUM_REGS = 1 << REG_AW;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [CNT_W-1:0]      r_cnt     [NUM_REGS];
  logic [KILL_DEPTH-1:0] r_hv;
  logic [REG_AW-1:0]     r_hrd     [KILL_DEPTH];
  logic [CNT_W-1:0]      r_hsaved  [KILL_DEPTH];
  logic [PERF_W-1:0]     r_stall_cycles;

  logic [CNT_W-1:0]      w_cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]      w_rd_aged;
  logic [NUM_REGS-1:0]   w_busy;
  logic                  w_stall;
  logic                  w_fire;
  logic                  w_wr;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  // cnt[0] is never loaded, so r0 reads can never stall.
  assign w_stall = i_issue_valid & ~i_redirect &
                   ((i_issue_rs_rd & (r_cnt[i_issue_rs] != '0)) |
                    (i_issue_rt_rd & (r_cnt[i_issue_rt] != '0)));
  assign w_fire  = i_issue_valid & ~w_stall & ~i_redirect;
  assign w_wr    = w_fire & i_issue_wen & (i_issue_rd != '0);

  // Destination counter as it would be next cycle without this issue. Used both
  // for the WAW max and as the history snapshot, so a later restore lands on
  // exactly the value the older result would have reached.
  assign w_rd_aged = sat_dec(r_cnt[i_issue_rd]);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt[r] = (r == 0) ? '0 : sat_dec(r_cnt[r]);
    end
    if (i_redirect) begin
      // Youngest first so the oldest entry for a shared rd is applied last.
      for (int k = 0; k < KILL_DEPTH; k++) begin
        if (r_hv[k]) begin
          w_cnt_nxt[r_hrd[k]] = sat_dec(r_hsaved[k]);
        end
      end
    end else if (w_wr) begin
      w_cnt_nxt[i_issue_rd] = (w_rd_aged > i_issue_lat) ? w_rd_aged : i_issue_lat;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_hv <= '0;
      for (int k = 0; k < KILL_DEPTH; k++) begin
        r_hrd[k]    <= '0;
        r_hsaved[k] <= '0;
      end
      r_stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      // Index 0 is the youngest entry; snapshots age in step with the counters.
      for (int k = KILL_DEPTH - 1; k > 0; k--) begin
        r_hv[k]     <= r_hv[k-1] & ~i_redirect;
        r_hrd[k]    <= r_hrd[k-1];
        r_hsaved[k] <= sat_dec(r_hsaved[k-1]);
      end
      r_hv[0]     <= w_wr;
      r_hrd[0]    <= i_issue_rd;
      r_hsaved[0] <= w_rd_aged;
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_ONE;
      end
    end
  end

  assign o_stall        = w_stall;
  assign o_issue_fire   = w_fire;
  assign o_busy_mask    = w_busy;
  assign o_stall_cycles = r_stall_cycles;

endmodule
